alu_multicycle_exec: RTL
========================

// Module: alu_multicycle_exec
// PURPOSE
//  Execution unit that consumes the 4-bit ALU operation code produced by the ALU control decoder.
//  - Performs ADD/SUB/AND/OR/XOR/LUI/SRL/SLL on two operands.
//  - Uses a valid/ready handshake on both the input and the output side.
//  - Logic ops complete in one cycle; shifts run iteratively, one bit per cycle.
//  - Sits between the operand muxes and the writeback/flag logic.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width; must be > 12 (LUI)
//  SHAMT_WIDTH   5  shift-amount bits taken from B_i[SHAMT_WIDTH-1:0]
// PORTS
//  clk              in   1           single clock, rising edge
//  reset            in   1           synchronous, active-high
//  ALU_Operation_i  in   4           op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR,
//                                    0100 XOR, 0101 LUI, 0110 SRL, 0111 SLL
//  A_i              in   DATA_WIDTH  operand A
//  B_i              in   DATA_WIDTH  operand B / immediate / shift amount
//  valid_i          in   1           request present
//  ready_o          out  1           unit can accept (IDLE state only)
//  ALU_Result_o     out  DATA_WIDTH  registered result
//  Zero_o           out  1           registered (ALU_Result_o == 0)
//  Illegal_Op_o     out  1           op code 1000..1111 was accepted
//  valid_o          out  1           result available
//  ready_i          in   1           consumer takes result
// BEHAVIOUR
//  - Reset: state IDLE; ALU_Result_o=0, Zero_o=0, Illegal_Op_o=0, valid_o=0.
//    ready_o=0 while reset is high. Reset mid-operation aborts the op, discards it and never asserts valid_o.
//  - FSM IDLE -> {SHIFT | DONE} -> IDLE. ready_o = (state==IDLE) && !reset.
//  - Accept on the edge where valid_i && ready_o; op, A_i and B_i are captured at that edge.
//    Inputs are ignored in all other cycles.
//  - Non-shift / illegal op at the accept edge: compute, register the result, go to DONE. Latency 1.
//  - Shift op: shamt = B_i[SHAMT_WIDTH-1:0]; upper bits of B_i are ignored.
//    - shamt==0: result = A, go to DONE.
//    - otherwise: load A into the shift register, cnt = shamt, go to SHIFT.
//    - SHIFT: each edge shifts by 1 (SLL: <<1 zero fill; SRL: logical >>1 zero fill) and decrements cnt.
//      Exit to DONE on the edge where cnt==1.
//    - Latency = 1 + shamt cycles from the accept edge to the first cycle valid_o is high.
//  - Arithmetic: ADD/SUB modulo 2^DATA_WIDTH, no carry or overflow out.
//    LUI = {B_i[DATA_WIDTH-13:0], 12'b0}.
//  - Illegal op: result 0, Zero_o=1, Illegal_Op_o=1, latency 1.
//  - DONE: valid_o=1; ALU_Result_o, Zero_o and Illegal_Op_o are held stable until valid_o && ready_i.
//    That edge goes to IDLE and clears valid_o and Illegal_Op_o.
//    No same-cycle re-accept: back-to-back single-cycle ops issue every 2 cycles.
//  - ready_i while valid_o is low is ignored.
// CONFIGURATION
//  ALU_BARREL_SHIFT_EN defined: shifts are done combinationally at the accept edge.
//    - Latency is 1 for every op; the SHIFT state is never entered.
//  ALU_BARREL_SHIFT_EN undefined: iterative shifting as described above. Results are identical in both builds.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - op-code localparams ALU_ADD..ALU_SLL;
//    - the illegal-range check;
//    - FSM state encoding IDLE/SHIFT/DONE.
//  - Sub-module alu_shift_unit: shift register plus down-counter with load/step/last outputs.
//    It is bypassed when ALU_BARREL_SHIFT_EN is defined.
// TESTING
//  1. ADD A=5 B=7 -> ALU_Result_o=12, Zero_o=0, valid_o in the cycle after accept.
//     SUB 3-3 -> 0 with Zero_o=1; SUB 0-1 -> 0xFFFFFFFF.
//  2. SLL A=1 B=31 -> 0x80000000, latency 32. SRL A=0x80000000 B=4 -> 0x08000000, latency 5.
//     SLL B=0x25 -> shamt 5, A<<5, latency 6.
//  3. SLL A=0xABCD B=0 -> 0xABCD, latency 1. With ALU_BARREL_SHIFT_EN, case 2 all complete with latency 1.
//  4. Backpressure: hold ready_i=0 for 3 cycles in DONE -> valid_o, result and Zero_o stable, ready_o=0.
//     A valid_i pulse in that window is ignored; ready_i=1 -> IDLE next cycle.
//  5. Reset at cycle 5 of SLL shamt=20 -> valid_o never rises, ready_o=1 after reset drops.
//     A following AND 0xF0 & 0x3C -> 0x30.
//  6. Op 4'b1010 -> result 0, Illegal_Op_o=1, Zero_o=1, latency 1. LUI B=0x12345 -> 0x12345000, Illegal_Op_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU execution unit: op codes,
// op classification helpers and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Codes 1000..1111 are reserved by the control decoder.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_multicycle_exec_if.sv
// Request/response bus of the ALU execution unit; the slave modport is the
// unit itself, the master modport is the issuing/consuming logic.
interface alu_multicycle_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;
  logic                  Illegal_Op_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  ALU_Operation_i, A_i, B_i, valid_i, ready_i,
    output ready_o, ALU_Result_o, Zero_o, Illegal_Op_o, valid_o
  );

  modport master (
    output ALU_Operation_i, A_i, B_i, valid_i, ready_i,
    input  ready_o, ALU_Result_o, Zero_o, Illegal_Op_o, valid_o
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: shift register plus down-counter.
// last_o flags the step that produces the final shifted value (next_o).
module alu_shift_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   left_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] cnt_i,
  output logic [DATA_WIDTH-1:0]  next_o,
  output logic                   last_o
);

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   left_q, left_d;

  assign next_o = left_q ? (data_q << 1) : (data_q >> 1);
  assign last_o = (cnt_q == SHAMT_WIDTH'(1));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (load) begin
      data_d = data_i;
      cnt_d  = cnt_i;
      left_d = left_i;
    end else if (step) begin
      data_d = next_o;
      cnt_d  = cnt_q - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// ALU execution unit with valid/ready on both sides. Shifts are iterative
// unless ALU_BARREL_SHIFT_EN is defined, in which case every op takes one cycle.
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic                 clk,
  input logic                 reset,
  alu_multicycle_exec_if.slave bus
);

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0]  alu_fn;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   accept;
  logic                   unused_b;

  assign unused_b = &{1'b0, bus.B_i};
  assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];

  assign bus.ready_o      = (state_q == ST_IDLE) && !reset;
  assign bus.valid_o      = (state_q == ST_DONE);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;
  assign bus.Illegal_Op_o = illegal_q;
  assign accept           = bus.valid_i && bus.ready_o;

  // Shifts by zero (and all shifts in the barrel build) resolve here directly.
  always_comb begin
    alu_fn = '0;
    case (bus.ALU_Operation_i)
      ALU_ADD: alu_fn = bus.A_i + bus.B_i;
      ALU_SUB: alu_fn = bus.A_i - bus.B_i;
      ALU_AND: alu_fn = bus.A_i & bus.B_i;
      ALU_OR:  alu_fn = bus.A_i | bus.B_i;
      ALU_XOR: alu_fn = bus.A_i ^ bus.B_i;
      ALU_LUI: alu_fn = {bus.B_i[DATA_WIDTH-13:0], 12'b0};
      ALU_SRL: alu_fn = bus.A_i >> shamt;
      ALU_SLL: alu_fn = bus.A_i << shamt;
      default: alu_fn = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  logic                  iter_shift;
  logic                  sh_last;
  logic [DATA_WIDTH-1:0] sh_next;
  assign iter_shift = 1'b0;
  assign sh_last    = 1'b0;
  assign sh_next    = '0;
`else
  logic                  iter_shift;
  logic                  sh_last;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  sh_load;
  logic                  sh_step;

  assign iter_shift = is_shift_op(bus.ALU_Operation_i) && (shamt != '0);
  assign sh_load    = (state_q == ST_IDLE) && accept && iter_shift
                      && !is_illegal_op(bus.ALU_Operation_i);
  assign sh_step    = (state_q == ST_SHIFT);

  alu_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .step  (sh_step),
    .left_i(bus.ALU_Operation_i == ALU_SLL),
    .data_i(bus.A_i),
    .cnt_i (shamt),
    .next_o(sh_next),
    .last_o(sh_last)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_illegal_op(bus.ALU_Operation_i)) begin
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else if (iter_shift) begin
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_fn;
            zero_d   = (alu_fn == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          result_d = sh_next;
          zero_d   = (sh_next == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) begin
          illegal_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
